// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point sequencer: the state
// encoding, the registered control-word layout and the format constants.
package fp_pkg;

    localparam int FP_BIAS    = 127;
    localparam int FRAC_W     = 26;
    localparam int ALIGN_SAT  = 26;
    localparam int RENORM_MAX = 1;

    typedef enum logic [2:0] {
        IDLE,
        EXP,
        ALIGN,
        BIAS,
        OP,
        NORM,
        ROUND,
        DONE
    } fp_state_t;

    // Datapath control word; every field is registered as one unit.
    typedef struct packed {
        logic       soma_multiplica_small_ula;
        logic       soma_multiplica_big_ula;
        logic       subtrador_big_ula;
        logic       subtrador_somador_subtrador;
        logic       decisor_mux_expoente_escolhido;
        logic       decisor_mux_saida_big_ula;
        logic       decisor_shift_right_left;
        logic [4:0] tamanho;
        logic [4:0] tamanho2;
        logic [7:0] tamanho3;
    } fp_ctrl_t;

endpackage

// File: rtl/fp_lzc26.sv
// Combinational 26-bit leading-zero counter; an all-zero input returns 26.
module fp_lzc26
    import fp_pkg::*;
(
    input  logic [FRAC_W-1:0] frac,
    output logic [4:0]        count
);

    // seen[i] is high once any bit at or above position i is set
    logic [FRAC_W-1:0] seen;

    genvar gi;
    generate
        for (gi = 0; gi < FRAC_W; gi++) begin : g_seen
            assign seen[gi] = |frac[FRAC_W-1:gi];
        end
    endgenerate

    always_comb begin
        count = '0;
        for (int i = 0; i < FRAC_W; i++) begin
            count = count + {4'b0000, ~seen[i]};
        end
    end

endmodule

// File: rtl/fp_control_unit.sv
// Sequencer for the floating-point add/multiply datapath. Outputs are decoded
// for the state being entered and registered with it, so they hold for the whole state.
module fp_control_unit
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [7:0]        exp_diff,
    input  logic              big_carry,
    input  logic [FRAC_W-1:0] frac_result,
    input  logic              round_overflow,
    output logic              soma_multiplica_small_ula,
    output logic              soma_multiplica_big_ula,
    output logic              subtrador_big_ula,
    output logic              subtrador_Somador_subtrador,
    output logic              decisor_mux_expoente_escolhido,
    output logic              decisor_mux_saida_big_ula,
    output logic              decisor_shift_right_left,
    output logic [4:0]        tamanho,
    output logic [4:0]        tamanho2,
    output logic [7:0]        tamanho3,
    output logic              busy,
    output logic              done,
    output logic              zero_result,
    output logic              error
);

    fp_state_t  state_reg, state_next;
    fp_ctrl_t   ctrl_reg, ctrl_next;
    logic       op_reg, op_next;
    logic [1:0] renorm_reg, renorm_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic       zero_reg, zero_next;
    logic       error_reg, error_next;
    logic       renorm_pass;
    logic [4:0] lz;

    fp_lzc26 u_lzc (
        .frac  (frac_result),
        .count (lz)
    );

    always_comb begin
        state_next  = state_reg;
        ctrl_next   = '0;
        op_next     = op_reg;
        renorm_next = renorm_reg;
        zero_next   = 1'b0;
        error_next  = error_reg;
        renorm_pass = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next     = op;
                    renorm_next = '0;
                    state_next  = EXP;
                end
            end
            EXP:   state_next = op_reg ? BIAS : ALIGN;
            ALIGN: state_next = OP;
            BIAS:  state_next = OP;
            OP:    state_next = NORM;
            NORM: begin
                if (!big_carry && frac_result == '0) begin
                    zero_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                if (!round_overflow) begin
                    state_next = DONE;
                end else if (int'(renorm_reg) < RENORM_MAX) begin
                    renorm_next = renorm_reg + 2'd1;
                    renorm_pass = 1'b1;
                    state_next  = NORM;
                end else begin
                    error_next = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        case (state_next)
            EXP: ctrl_next.soma_multiplica_small_ula = ~op_next;
            ALIGN: begin
                if (exp_diff >= 8'(ALIGN_SAT)) begin
                    ctrl_next.tamanho = 5'(ALIGN_SAT);
                end else begin
                    ctrl_next.tamanho = exp_diff[4:0];
                end
            end
            BIAS: begin
                ctrl_next.tamanho3                    = 8'(FP_BIAS);
                ctrl_next.subtrador_somador_subtrador = 1'b1;
            end
            OP: ctrl_next.soma_multiplica_big_ula = ~op_reg;
            NORM: begin
                // Renormalization re-feeds the rounded result and its exponent.
                ctrl_next.decisor_mux_saida_big_ula      = renorm_pass;
                ctrl_next.decisor_mux_expoente_escolhido = renorm_pass;
                if (big_carry) begin
                    ctrl_next.tamanho2 = 5'd1;
                    ctrl_next.tamanho3 = 8'd1;
                end else if (frac_result != '0) begin
                    ctrl_next.decisor_shift_right_left    = 1'b1;
                    ctrl_next.tamanho2                    = lz;
                    ctrl_next.tamanho3                    = {3'b000, lz};
                    ctrl_next.subtrador_somador_subtrador = 1'b1;
                end
            end
            default: ;
        endcase

        busy_next = (state_next != IDLE) && (state_next != DONE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            ctrl_reg   <= '0;
            op_reg     <= 1'b0;
            renorm_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ctrl_reg   <= ctrl_next;
            op_reg     <= op_next;
            renorm_reg <= renorm_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            zero_reg   <= zero_next;
            error_reg  <= error_next;
        end
    end

    assign soma_multiplica_small_ula      = ctrl_reg.soma_multiplica_small_ula;
    assign soma_multiplica_big_ula        = ctrl_reg.soma_multiplica_big_ula;
    assign subtrador_big_ula              = ctrl_reg.subtrador_big_ula;
    assign subtrador_Somador_subtrador    = ctrl_reg.subtrador_somador_subtrador;
    assign decisor_mux_expoente_escolhido = ctrl_reg.decisor_mux_expoente_escolhido;
    assign decisor_mux_saida_big_ula      = ctrl_reg.decisor_mux_saida_big_ula;
    assign decisor_shift_right_left       = ctrl_reg.decisor_shift_right_left;
    assign tamanho                        = ctrl_reg.tamanho;
    assign tamanho2                       = ctrl_reg.tamanho2;
    assign tamanho3                       = ctrl_reg.tamanho3;
    assign busy                           = busy_reg;
    assign done                           = done_reg;
    assign zero_result                    = zero_reg;
    assign error                          = error_reg;

endmodule

// File: tb/tb_fp_control_unit.sv
// Directed bench for fp_control_unit: each scenario records the outputs of
// every cycle of one operation and compares them to hand-derived values.
module tb_fp_control_unit;

    logic        clk = 1'b0;
    logic        reset, start, op, big_carry, round_overflow;
    logic [7:0]  exp_diff;
    logic [25:0] frac_result;
    logic        soma_small, soma_big, sub_big, sub_ss, mux_exp, mux_saida, shift_rl;
    logic [4:0]  tamanho, tamanho2;
    logic [7:0]  tamanho3;
    logic        busy, done, zero_result, error;

    typedef struct packed {
        logic       soma_small;
        logic       soma_big;
        logic       sub_big;
        logic       sub_ss;
        logic       mux_exp;
        logic       mux_saida;
        logic       shift_rl;
        logic [4:0] tamanho;
        logic [4:0] tamanho2;
        logic [7:0] tamanho3;
        logic       busy;
        logic       done;
        logic       zero_result;
        logic       error;
    } obs_t;

    obs_t obs [0:12];
    int   done_cyc;
    int   done_cnt;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fp_control_unit dut (
        .clk                            (clk),
        .reset                          (reset),
        .start                          (start),
        .op                             (op),
        .exp_diff                       (exp_diff),
        .big_carry                      (big_carry),
        .frac_result                    (frac_result),
        .round_overflow                 (round_overflow),
        .soma_multiplica_small_ula      (soma_small),
        .soma_multiplica_big_ula        (soma_big),
        .subtrador_big_ula              (sub_big),
        .subtrador_Somador_subtrador    (sub_ss),
        .decisor_mux_expoente_escolhido (mux_exp),
        .decisor_mux_saida_big_ula      (mux_saida),
        .decisor_shift_right_left       (shift_rl),
        .tamanho                        (tamanho),
        .tamanho2                       (tamanho2),
        .tamanho3                       (tamanho3),
        .busy                           (busy),
        .done                           (done),
        .zero_result                    (zero_result),
        .error                          (error)
    );

    function automatic obs_t sample();
        obs_t s;
        s = {soma_small, soma_big, sub_big, sub_ss, mux_exp, mux_saida, shift_rl,
             tamanho, tamanho2, tamanho3, busy, done, zero_result, error};
        return s;
    endfunction

    // Cycle 0 is the cycle in which start is sampled; obs[c] holds cycle c.
    task automatic run_op(input logic o, input logic [7:0] ed, input logic bc,
                          input logic [25:0] fr, input logic ro5, input logic ro7,
                          input logic hold_start, input int rst_at);
        op = o; exp_diff = ed; big_carry = bc; frac_result = fr;
        start = 1'b1; round_overflow = 1'b0; reset = 1'b0;
        done_cyc = -1; done_cnt = 0;
        obs[0] = sample();
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            obs[c] = sample();
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            start          = hold_start && (c <= 3);
            round_overflow = (c == 5 && ro5) || (c == 7 && ro7);
            reset          = (c == rst_at);
        end
        start = 1'b0; round_overflow = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t s;
        reset = 1'b1; start = 1'b0; op = 1'b0; exp_diff = '0; big_carry = 1'b0;
        frac_result = '0; round_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1; reset = 1'b0;
        s = sample();
        n_checks++;
        if (s !== '0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", s); end
        $display("reset: outputs=%h", s);
    endtask

    task automatic test_add_nominal();
        run_op(1'b0, 8'd3, 1'b0, 26'h2000000, 1'b0, 1'b0, 1'b0, -1);
        n_checks++; if (obs[1].soma_small !== 1'b1) begin n_fail++; $display("FAIL add_exp_small got %b want 1", obs[1].soma_small); end
        n_checks++; if (obs[1].busy !== 1'b1) begin n_fail++; $display("FAIL add_busy got %b want 1", obs[1].busy); end
        n_checks++; if (obs[2].tamanho !== 5'd3) begin n_fail++; $display("FAIL add_align_tamanho got %0d want 3", obs[2].tamanho); end
        n_checks++; if (obs[3].soma_big !== 1'b1 || obs[3].sub_big !== 1'b0) begin n_fail++; $display("FAIL add_op got soma=%b sub=%b want 1 0", obs[3].soma_big, obs[3].sub_big); end
        n_checks++; if (obs[4].tamanho2 !== 5'd0 || obs[4].shift_rl !== 1'b1) begin n_fail++; $display("FAIL add_norm got t2=%0d dir=%b want 0 1", obs[4].tamanho2, obs[4].shift_rl); end
        n_checks++; if (obs[5] !== obs_t'(4'b1000)) begin n_fail++; $display("FAIL add_round_outputs got %h want only busy", obs[5]); end
        n_checks++; if (done_cyc !== 6 || done_cnt !== 1) begin n_fail++; $display("FAIL add_done got cycle %0d count %0d want 6 1", done_cyc, done_cnt); end
        n_checks++; if (obs[6].busy !== 1'b0 || obs[6].zero_result !== 1'b0) begin n_fail++; $display("FAIL add_done_flags got busy=%b zero=%b want 0 0", obs[6].busy, obs[6].zero_result); end
        $display("add ed=3: tamanho=%0d tamanho2=%0d done_cycle=%0d", obs[2].tamanho, obs[4].tamanho2, done_cyc);
    endtask

    task automatic test_align_sat();
        logic [7:0] eds [3] = '{8'd40, 8'd26, 8'd25};
        logic [4:0] exp_t [3] = '{5'd26, 5'd26, 5'd25};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, eds[i], 1'b0, 26'h1000000, 1'b0, 1'b0, 1'b0, -1);
            n_checks++; if (obs[2].tamanho !== exp_t[i]) begin n_fail++; $display("FAIL align_sat ed=%0d got %0d want %0d", eds[i], obs[2].tamanho, exp_t[i]); end
            n_checks++; if (done_cyc !== 6) begin n_fail++; $display("FAIL align_done ed=%0d got %0d want 6", eds[i], done_cyc); end
            $display("align ed=%0d: tamanho=%0d done_cycle=%0d", eds[i], obs[2].tamanho, done_cyc);
        end
    endtask

    task automatic test_mul_carry();
        run_op(1'b1, 8'd5, 1'b1, 26'h3000000, 1'b0, 1'b0, 1'b0, -1);
        n_checks++; if (obs[1].soma_small !== 1'b0 || obs[1].busy !== 1'b1) begin n_fail++; $display("FAIL mul_exp got small=%b busy=%b want 0 1", obs[1].soma_small, obs[1].busy); end
        n_checks++; if (obs[2].tamanho3 !== 8'd127 || obs[2].sub_ss !== 1'b1 || obs[2].tamanho !== 5'd0) begin n_fail++; $display("FAIL mul_bias got t3=%0d sub=%b t=%0d want 127 1 0", obs[2].tamanho3, obs[2].sub_ss, obs[2].tamanho); end
        n_checks++; if (obs[3].soma_big !== 1'b0 || obs[3].tamanho3 !== 8'd0) begin n_fail++; $display("FAIL mul_op got soma=%b t3=%0d want 0 0", obs[3].soma_big, obs[3].tamanho3); end
        n_checks++; if (obs[4].shift_rl !== 1'b0 || obs[4].tamanho2 !== 5'd1 || obs[4].tamanho3 !== 8'd1 || obs[4].sub_ss !== 1'b0) begin n_fail++; $display("FAIL mul_norm got dir=%b t2=%0d t3=%0d sub=%b want 0 1 1 0", obs[4].shift_rl, obs[4].tamanho2, obs[4].tamanho3, obs[4].sub_ss); end
        n_checks++; if (done_cyc !== 6) begin n_fail++; $display("FAIL mul_done got %0d want 6", done_cyc); end
        $display("mul carry: bias t3=%0d norm t2=%0d done_cycle=%0d", obs[2].tamanho3, obs[4].tamanho2, done_cyc);
    endtask

    task automatic test_left_shift();
        run_op(1'b0, 8'd0, 1'b0, 26'h0000100, 1'b0, 1'b0, 1'b0, -1);
        n_checks++; if (obs[4].tamanho2 !== 5'd17 || obs[4].tamanho3 !== 8'd17) begin n_fail++; $display("FAIL lshift_amount got t2=%0d t3=%0d want 17 17", obs[4].tamanho2, obs[4].tamanho3); end
        n_checks++; if (obs[4].shift_rl !== 1'b1 || obs[4].sub_ss !== 1'b1) begin n_fail++; $display("FAIL lshift_ctrl got dir=%b sub=%b want 1 1", obs[4].shift_rl, obs[4].sub_ss); end
        $display("left shift frac=0000100: tamanho2=%0d tamanho3=%0d", obs[4].tamanho2, obs[4].tamanho3);
    endtask

    task automatic test_renorm();
        run_op(1'b0, 8'd1, 1'b0, 26'h2000000, 1'b1, 1'b0, 1'b0, -1);
        n_checks++; if (obs[6].mux_saida !== 1'b1 || obs[6].mux_exp !== 1'b1) begin n_fail++; $display("FAIL renorm_mux got saida=%b exp=%b want 1 1", obs[6].mux_saida, obs[6].mux_exp); end
        n_checks++; if (obs[4].mux_saida !== 1'b0 || obs[8].mux_saida !== 1'b0 || obs[8].mux_exp !== 1'b0) begin n_fail++; $display("FAIL renorm_mux_idle got n4=%b d8=%b/%b want 0", obs[4].mux_saida, obs[8].mux_saida, obs[8].mux_exp); end
        n_checks++; if (done_cyc !== 8 || done_cnt !== 1 || obs[8].error !== 1'b0) begin n_fail++; $display("FAIL renorm_done got cycle %0d count %0d err %b want 8 1 0", done_cyc, done_cnt, obs[8].error); end
        $display("renorm: mux=%b%b done_cycle=%0d", obs[6].mux_saida, obs[6].mux_exp, done_cyc);
    endtask

    task automatic test_error_sticky();
        run_op(1'b0, 8'd1, 1'b0, 26'h2000000, 1'b1, 1'b1, 1'b0, -1);
        n_checks++; if (obs[8].error !== 1'b1 || done_cyc !== 8) begin n_fail++; $display("FAIL error_set got err=%b done %0d want 1 8", obs[8].error, done_cyc); end
        n_checks++; if (obs[7].error !== 1'b0) begin n_fail++; $display("FAIL error_early got %b want 0", obs[7].error); end
        run_op(1'b0, 8'd3, 1'b0, 26'h2000000, 1'b0, 1'b0, 1'b0, -1);
        n_checks++; if (obs[6].error !== 1'b1 || done_cyc !== 6) begin n_fail++; $display("FAIL error_sticky got err=%b done %0d want 1 6", obs[6].error, done_cyc); end
        $display("error: set=%b sticky=%b", obs[8].error, obs[6].error);
    endtask

    task automatic test_zero();
        run_op(1'b0, 8'd2, 1'b0, 26'h0, 1'b0, 1'b0, 1'b0, -1);
        n_checks++; if (done_cyc !== 5 || obs[5].zero_result !== 1'b1) begin n_fail++; $display("FAIL zero_done got cycle %0d zero %b want 5 1", done_cyc, obs[5].zero_result); end
        n_checks++; if (obs[6].zero_result !== 1'b0 || obs[4].zero_result !== 1'b0) begin n_fail++; $display("FAIL zero_pulse got c4=%b c6=%b want 0 0", obs[4].zero_result, obs[6].zero_result); end
        $display("zero: done_cycle=%0d zero_result=%b", done_cyc, obs[5].zero_result);
    endtask

    task automatic test_start_ignored();
        run_op(1'b0, 8'd3, 1'b0, 26'h2000000, 1'b0, 1'b0, 1'b1, -1);
        n_checks++; if (obs[2].tamanho !== 5'd3 || done_cyc !== 6 || done_cnt !== 1) begin n_fail++; $display("FAIL start_ignored got t=%0d done %0d count %0d want 3 6 1", obs[2].tamanho, done_cyc, done_cnt); end
        $display("start held while busy: done_cycle=%0d count=%0d", done_cyc, done_cnt);
    endtask

    task automatic test_reset_mid();
        run_op(1'b1, 8'd3, 1'b1, 26'h2000000, 1'b0, 1'b0, 1'b1, 3);
        n_checks++; if (obs[4] !== '0) begin n_fail++; $display("FAIL reset_mid_outputs got %h want 0", obs[4]); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL reset_mid_done got %0d pulses want 0", done_cnt); end
        n_checks++; if (obs[3].busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy got %b want 1", obs[3].busy); end
        $display("reset mid-op: outputs after=%h done pulses=%0d", obs[4], done_cnt);
    endtask

    initial begin
        test_reset();
        test_add_nominal();
        test_align_sat();
        test_mul_carry();
        test_left_shift();
        test_renorm();
        test_error_sticky();
        test_zero();
        test_start_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_control_unit.md
FP_CONTROL_UNIT -- requirements
Module: fp_control_unit

Interface
REQ-001 Clock and reset: one clock, synchronous active-high reset; ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; forces IDLE and output defaults.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  1  0 = add, 1 = multiply; captured with start.
REQ-006 exp_diff  input  8  registered small-ULA result (saida_registrador).
REQ-007 big_carry  input  1  carry-out of the big ULA sum.
REQ-008 frac_result  input  26  big-ULA/mux fraction; the hidden bit sits at [25] when normalized.
REQ-009 round_overflow  input  1  overflow flag from the rounding stage.
REQ-010 Datapath control outputs, each registered:
- soma_multiplica_small_ula 1
- soma_multiplica_big_ula 1
- subtrador_big_ula 1
- subtrador_Somador_subtrador 1
- decisor_mux_expoente_escolhido 1
- decisor_mux_saida_big_ula 1
- decisor_shift_right_left 1
- tamanho 5
- tamanho2 5
- tamanho3 8
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 zero_result  output  1  valid with done; the fraction was zero.
REQ-014 error  output  1  sticky; set on a second consecutive round overflow.

Function
REQ-015 States are IDLE, EXP, ALIGN, BIAS, OP, NORM, ROUND, DONE.

REQ-016 IDLE:
- When start=1, captures op, sets busy, and goes to EXP.
- start is ignored in every other state.

REQ-017 EXP: drives soma_multiplica_small_ula=1 for add (difference) and 0 for mul (sum), then goes to ALIGN for add or to BIAS for mul.

REQ-018 ALIGN (add only):
- tamanho = min(exp_diff, 26), saturating.
- When exp_diff >= 26, the shifted operand is all-zero.
- Next state is OP.

REQ-019 BIAS (mul only):
- tamanho3=127 and subtrador_Somador_subtrador=1, which removes the doubled bias.
- tamanho=0.
- Next state is OP.

REQ-020 OP:
- soma_multiplica_big_ula=1 for add, 0 for mul.
- subtrador_big_ula=0 in this revision; sign-based subtraction is reserved.
- Next state is NORM.

REQ-021 NORM, with lz = leading-zero count of frac_result:
- big_carry=1: decisor_shift_right_left=0, tamanho2=1, tamanho3=1, subtrador_Somador_subtrador=0.
- big_carry=0 and frac_result nonzero: decisor_shift_right_left=1, tamanho2=lz, tamanho3=lz, subtrador_Somador_subtrador=1.
- frac_result=0 and big_carry=0: sets zero_result and goes directly to DONE.
- Otherwise the next state is ROUND.

REQ-022 ROUND:
- round_overflow=0 -> DONE.
- round_overflow=1 and this is the first overflow of the operation -> NORM, with decisor_mux_saida_big_ula=1 and decisor_mux_expoente_escolhido=1 for the renormalization pass.
- round_overflow=1 and one overflow has already occurred -> set error and go to DONE.

REQ-023 DONE: done=1 for one cycle, busy drops, next state is IDLE, and all mux selects return to 0.

REQ-024 Latency, counting the start-sampled cycle as 0:
- done at cycle 6 nominally.
- done at cycle 8 with one renormalization.
- done at cycle 5 for a zero fraction.

REQ-025 Shift fields are 5 bits and never exceed 26. Exponent adjustment tamanho3 is 8 bits and is zero-extended from the shift count.

REQ-026 Control outputs hold their values for the whole state cycle and are 0 in states where they are not named.

Reset
REQ-027 On reset:
- State = IDLE.
- All control outputs, busy, done, zero_result and error = 0.
- The renormalization flag is cleared.

REQ-028 Reset asserted mid-operation aborts in the same edge and produces no done pulse.

REQ-029 error clears only on reset.

Structure
REQ-030 Shared package fp_pkg holds:
- the state enum;
- constants FP_BIAS=127, FRAC_W=26, ALIGN_SAT=26, RENORM_MAX=1.

REQ-031 Sub-module fp_lzc26 is a combinational 26-bit leading-zero counter:
- output is 5 bits;
- input 0 returns 26.

REQ-032 Next-state and output decode are in one combinational block, registered on clk.

Verification
REQ-033 Add, exp_diff=3, big_carry=0, frac_result=26'h2000000:
- tamanho=3 in ALIGN;
- tamanho2=0 in NORM;
- done at cycle 6.

REQ-034 Add, exp_diff=40:
- tamanho=26 (saturated);
- done at cycle 6.

REQ-035 Mul, big_carry=1:
- BIAS drives tamanho3=127 with subtract;
- NORM drives a right shift of 1 with tamanho3=1 increment.

REQ-036 frac_result=26'h0000100, big_carry=0:
- NORM drives a left shift with tamanho2=17 and tamanho3=17 subtract.

REQ-037 round_overflow=1 on the first ROUND:
- returns to NORM with both feedback mux selects=1;
- done at cycle 8.
round_overflow=1 again on the second ROUND: error=1.

REQ-038 Zero fraction: zero_result=1 with done at cycle 5. Reset asserted at cycle 3: no done, all outputs 0 the following cycle, and start=1 while busy is ignored.
